i2c_controller: RTL

// I2C initiator (controller) for a single-controller bus, run on system clock.

---
 rtl/i2c_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/i2c_controller.sv
// Single-controller I2C initiator: START, {addr,rw}, cmd_len data bytes, STOP; SCL push-pull, SDA open-drain.
// Latency: first SDA fall 2*CLK_DIV clks after accept; done at 4*CLK_DIV*(11+9*len) clks with every byte ACKed.
// Backpressure: cmd_ready only in Idle (requests while busy are dropped); tx_data must be valid when tx_ready pulses.
module i2c_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_len,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       nack_error,
  output logic       done,
  output logic       scl_out,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
  } state_t;

  state_t        state, next_state;
  logic [DW-1:0] div;
  logic [1:0]    qtr;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [3:0]    len;
  logic          rw;
  logic          ack_smp;
  logic          tick, slot_end, scl_lvl, sda_low;

  assign tick      = (state != IDLE) && (div == DIV_LAST);
  assign slot_end  = tick && (qtr == 2'd3);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign tx_ready  = (state == WRITE) && tick && (qtr == 2'd0) && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Bus levels computed here are registered on the tick that ends the quarter.
  always_comb begin
    next_state = state;
    scl_lvl    = 1'b1;
    sda_low    = 1'b0;
    case (state)
      IDLE: if (cmd_valid) next_state = START;
      START: begin
        scl_lvl = ~qtr[1];
        sda_low = (qtr != 2'd0);
        if (slot_end) next_state = ADDR;
      end
      ADDR: begin
        scl_lvl = qtr[1];
        sda_low = ~shreg[7];
        if (slot_end && bit_cnt == 3'd0) next_state = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_lvl = qtr[1];
        if (slot_end) begin
          if (ack_smp || len == 4'd0) next_state = STOP;
          else if (rw)                next_state = READ;
          else                        next_state = WRITE;
        end
      end
      WRITE: begin
        scl_lvl = qtr[1];
        sda_low = ~(tx_ready ? tx_data[7] : shreg[7]);
        if (slot_end && bit_cnt == 3'd0) next_state = WRITE_ACK;
      end
      WRITE_ACK: begin
        scl_lvl = qtr[1];
        if (slot_end) next_state = (ack_smp || len == 4'd1) ? STOP : WRITE;
      end
      READ: begin
        scl_lvl = qtr[1];
        if (slot_end && bit_cnt == 3'd0) next_state = READ_ACK;
      end
      READ_ACK: begin
        scl_lvl = qtr[1];
        sda_low = (len != 4'd1);
        if (slot_end) next_state = (len == 4'd1) ? STOP : READ;
      end
      STOP: begin
        scl_lvl = (qtr != 2'd0);
        sda_low = ~qtr[1];
        if (slot_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      qtr        <= 2'd0;
      bit_cnt    <= 3'd7;
      shreg      <= 8'h00;
      len        <= 4'd0;
      rw         <= 1'b0;
      ack_smp    <= 1'b0;
      scl_out    <= 1'b1;
      sda_out    <= 1'b1;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      nack_error <= 1'b0;
      done       <= 1'b0;
    end else begin
      rx_valid <= (state == READ) && slot_end && (bit_cnt == 3'd0);
      done     <= (state == STOP) && slot_end;
      if (state == IDLE || tick) div <= '0;
      else                       div <= div + 1'b1;
      if (state == IDLE) qtr <= 2'd0;
      else if (tick)     qtr <= qtr + 2'd1;
      if (tick) begin
        scl_out <= scl_lvl;
        sda_oe  <= sda_low;
        sda_out <= ~sda_low;
      end
      if (cmd_valid && cmd_ready) begin
        shreg      <= {cmd_addr, cmd_rw};
        len        <= cmd_len;
        rw         <= cmd_rw;
        bit_cnt    <= 3'd7;
        nack_error <= 1'b0;
      end else if (tx_ready) begin
        shreg <= tx_data;
      end else if (tick && qtr == 2'd2 && state == READ) begin
        shreg <= {shreg[6:0], sda_in};
      end else if (slot_end && (state == ADDR || state == WRITE)) begin
        shreg <= {shreg[6:0], 1'b0};
      end
      // bit_cnt wraps 0 -> 7, ready for the next byte.
      if (slot_end && (state == ADDR || state == WRITE || state == READ))
        bit_cnt <= bit_cnt - 3'd1;
      if (slot_end && state == READ && bit_cnt == 3'd0)
        rx_data <= shreg;
      if (tick && qtr == 2'd2 && (state == ADDR_ACK || state == WRITE_ACK))
        ack_smp <= sda_in;
      if (slot_end && (state == ADDR_ACK || state == WRITE_ACK) && ack_smp)
        nack_error <= 1'b1;
      if (slot_end && ((state == WRITE_ACK && !ack_smp) || state == READ_ACK))
        len <= len - 4'd1;
    end
  end
endmodule
